// File: rtl/timeslice_pkg.sv
// -----------------------------------------------------------------------------
// timeslice_pkg
//   Shared definitions for the time-slice arbiter: FSM state encoding and a
//   constant-evaluable clog2 helper used to size index and counter ports.
// -----------------------------------------------------------------------------
package timeslice_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin search. Scans req starting one past ptr and
//   wrapping modulo N_REQ; the first set bit wins.
//   Ports:
//     req  - request vector
//     ptr  - index of the most recent winner (search starts at ptr+1)
//     any  - at least one request is set
//     idx  - winning index (0 when any is 0)
// -----------------------------------------------------------------------------
module rr_picker
    import timeslice_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] ptr,
    output logic                    any,
    output logic [clog2(N_REQ)-1:0] idx
);

    localparam int IDX_W = clog2(N_REQ);

    always_comb begin
        logic [IDX_W-1:0] cand;
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        // Offset i = N_REQ reaches ptr itself last, so the previous winner is
        // chosen only when nobody else is asking.
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/timeslice_arbiter.sv
// -----------------------------------------------------------------------------
// timeslice_arbiter
//   Round-robin time-slice arbiter. An owner keeps the resource for QUANTUM
//   timer triggers; at expiry it is preempted if anyone else is waiting, or
//   renewed in place otherwise. Every hand-off inserts a one-cycle GAP.
//   Ports:
//     clk, sync_reset - clock and synchronous active-high reset
//     req             - level request per requester
//     timer_trigger   - tick from the external timer
//     timer_clear     - holds the timer cleared outside GRANT
//     timer_enable    - runs the timer during GRANT
//     grant           - one-hot owner, or zero
//     grant_valid     - OR of grant
//     grant_id        - owner index, 0 when no grant
//     preempt         - one-cycle pulse (during GAP) after expiry revocation
// -----------------------------------------------------------------------------
module timeslice_arbiter
    import timeslice_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int QUANTUM = 3
) (
    input  logic                    clk,
    input  logic                    sync_reset,
    input  logic [N_REQ-1:0]        req,
    input  logic                    timer_trigger,
    output logic                    timer_clear,
    output logic                    timer_enable,
    output logic [N_REQ-1:0]        grant,
    output logic                    grant_valid,
    output logic [clog2(N_REQ)-1:0] grant_id,
    output logic                    preempt
);

    localparam int ID_W  = clog2(N_REQ);
    localparam int CNT_W = (clog2(QUANTUM) < 1) ? 1 : clog2(QUANTUM);

    logic [1:0]       state;
    logic [ID_W-1:0]  owner;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] slice_cnt;

    logic             pick_any;
    logic [ID_W-1:0]  pick_idx;
    logic [N_REQ-1:0] owner_onehot;
    logic             others_pending;
    logic             expiry;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign owner_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
    assign others_pending = |(req & ~owner_onehot);
    assign expiry         = timer_trigger && (slice_cnt == CNT_W'(QUANTUM - 1));

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every branch
        // reads the pre-edge values, matching the flops that get built.
        if (sync_reset) begin
            state     <= ST_IDLE;
            owner     <= '0;
            ptr       <= ID_W'(N_REQ - 1);
            slice_cnt <= '0;
            preempt   <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                ST_IDLE, ST_GAP: begin
                    slice_cnt <= '0;
                    if (pick_any) begin
                        owner <= pick_idx;
                        ptr   <= pick_idx;
                        state <= ST_GRANT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    // Release wins over a coincident expiry, so no preempt.
                    if (!req[owner]) begin
                        state <= ST_GAP;
                    end else if (expiry) begin
                        if (others_pending) begin
                            preempt <= 1'b1;
                            state   <= ST_GAP;
                        end else begin
                            // Renewal: the timer keeps running, only the
                            // trigger count restarts.
                            slice_cnt <= '0;
                        end
                    end else if (timer_trigger) begin
                        slice_cnt <= slice_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // All outputs decode registered state only; req never reaches grant
    // combinationally.
    assign timer_enable = (state == ST_GRANT);
    assign timer_clear  = (state == ST_IDLE) || (state == ST_GAP);
    assign grant        = (state == ST_GRANT) ? owner_onehot : '0;
    assign grant_valid  = (state == ST_GRANT);
    assign grant_id     = (state == ST_GRANT) ? owner : '0;

endmodule

// File: tb/tb_timeslice_arbiter.sv
// -----------------------------------------------------------------------------
// tb_timeslice_arbiter
//   Directed bench for timeslice_arbiter (N_REQ=4, QUANTUM=3) with a
//   behavioural 4-cycle timer: trigger when enabled and its count reads 3.
// -----------------------------------------------------------------------------
module tb_timeslice_arbiter;

    localparam int N_REQ   = 4;
    localparam int QUANTUM = 3;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic [3:0] req;
    logic       timer_trigger;
    logic       timer_clear;
    logic       timer_enable;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       preempt;

    logic [1:0] tcnt = 2'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (timer_clear)
            tcnt <= 2'd0;
        else if (timer_enable)
            tcnt <= tcnt + 2'd1;
    end
    assign timer_trigger = timer_enable && (tcnt == 2'd3);

    timeslice_arbiter #(.N_REQ(N_REQ), .QUANTUM(QUANTUM)) dut (
        .clk           (clk),
        .sync_reset    (sync_reset),
        .req           (req),
        .timer_trigger (timer_trigger),
        .timer_clear   (timer_clear),
        .timer_enable  (timer_enable),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .preempt       (preempt)
    );

    // Observed outputs packed as {grant, valid, id, preempt, enable, clear}.
    wire [9:0] obs = {grant, grant_valid, grant_id, preempt, timer_enable, timer_clear};

    // Expected packed outputs: a grant implies GRANT state (enable=1, clear=0),
    // no grant implies IDLE/GAP (enable=0, clear=1).
    function automatic logic [9:0] expv(input logic [3:0] g, input logic [1:0] id,
                                        input logic p);
        return {g, |g, id, p, |g, ~|g};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sync_reset = 1'b1;
        req        = 4'b0000;
        step();
        step();
        sync_reset = 1'b0;
    endtask

    task automatic test_reset();
        sync_reset = 1'b1;
        req        = 4'b1111;
        step();
        step();
        checks++;
        if (obs !== expv(4'b0000, 2'd0, 1'b0)) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", obs, expv(4'b0000, 2'd0, 1'b0));
        end
        sync_reset = 1'b0;
        step();
        checks++;
        if (obs !== expv(4'b0001, 2'd0, 1'b0)) begin
            errors++;
            $display("FAIL first_grant: got %b expected %b", obs, expv(4'b0001, 2'd0, 1'b0));
        end
    endtask

    task automatic test_expiry();
        do_reset();
        req = 4'b0011;
        step();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (obs !== expv(4'b0001, 2'd0, 1'b0)) begin
                errors++;
                $display("FAIL slice_owner0 cyc %0d: got %b expected %b", i, obs,
                         expv(4'b0001, 2'd0, 1'b0));
            end
            step();
        end
        checks++;
        if (obs !== expv(4'b0000, 2'd0, 1'b1)) begin
            errors++;
            $display("FAIL gap_preempt0: got %b expected %b", obs, expv(4'b0000, 2'd0, 1'b1));
        end
        step();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (obs !== expv(4'b0010, 2'd1, 1'b0)) begin
                errors++;
                $display("FAIL slice_owner1 cyc %0d: got %b expected %b", i, obs,
                         expv(4'b0010, 2'd1, 1'b0));
            end
            step();
        end
        checks++;
        if (obs !== expv(4'b0000, 2'd0, 1'b1)) begin
            errors++;
            $display("FAIL gap_preempt1: got %b expected %b", obs, expv(4'b0000, 2'd0, 1'b1));
        end
        step();
        checks++;
        if (obs !== expv(4'b0001, 2'd0, 1'b0)) begin
            errors++;
            $display("FAIL back_to_owner0: got %b expected %b", obs, expv(4'b0001, 2'd0, 1'b0));
        end
    endtask

    task automatic test_renewal();
        do_reset();
        req = 4'b0100;
        step();
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (obs !== expv(4'b0100, 2'd2, 1'b0)) begin
                errors++;
                $display("FAIL renewal cyc %0d: got %b expected %b", i, obs,
                         expv(4'b0100, 2'd2, 1'b0));
            end
            step();
        end
        req = 4'b0000;
        step();
        checks++;
        if (obs !== expv(4'b0000, 2'd0, 1'b0)) begin
            errors++;
            $display("FAIL renewal_release_gap: got %b expected %b", obs, expv(4'b0000, 2'd0, 1'b0));
        end
        step();
        checks++;
        if (obs !== expv(4'b0000, 2'd0, 1'b0)) begin
            errors++;
            $display("FAIL renewal_idle: got %b expected %b", obs, expv(4'b0000, 2'd0, 1'b0));
        end
    endtask

    // Leaves owner 3 in the final trigger cycle of its slice with req=4'b1001.
    task automatic test_early_release();
        do_reset();
        req = 4'b1010;
        step();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs !== expv(4'b0010, 2'd1, 1'b0)) begin
                errors++;
                $display("FAIL early_owner1 cyc %0d: got %b expected %b", i, obs,
                         expv(4'b0010, 2'd1, 1'b0));
            end
            if (i < 5) step();
        end
        req = 4'b1000;
        step();
        checks++;
        if (obs !== expv(4'b0000, 2'd0, 1'b0)) begin
            errors++;
            $display("FAIL early_release_gap: got %b expected %b", obs, expv(4'b0000, 2'd0, 1'b0));
        end
        step();
        req = 4'b1001;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (obs !== expv(4'b1000, 2'd3, 1'b0)) begin
                errors++;
                $display("FAIL full_slice_owner3 cyc %0d: got %b expected %b", i, obs,
                         expv(4'b1000, 2'd3, 1'b0));
            end
            if (i < 11) step();
        end
        checks++;
        if (timer_trigger !== 1'b1) begin
            errors++;
            $display("FAIL final_trigger: got %b expected 1", timer_trigger);
        end
    endtask

    task automatic test_release_expiry_wrap();
        req = 4'b0001;
        step();
        checks++;
        if (obs !== expv(4'b0000, 2'd0, 1'b0)) begin
            errors++;
            $display("FAIL release_at_expiry: got %b expected %b", obs, expv(4'b0000, 2'd0, 1'b0));
        end
        step();
        checks++;
        if (obs !== expv(4'b0001, 2'd0, 1'b0)) begin
            errors++;
            $display("FAIL wrap_to_0: got %b expected %b", obs, expv(4'b0001, 2'd0, 1'b0));
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0100;
        step();
        req = 4'b1100;
        step();
        step();
        checks++;
        if (obs !== expv(4'b0100, 2'd2, 1'b0)) begin
            errors++;
            $display("FAIL nonowner_ignored: got %b expected %b", obs, expv(4'b0100, 2'd2, 1'b0));
        end
        sync_reset = 1'b1;
        step();
        checks++;
        if (obs !== expv(4'b0000, 2'd0, 1'b0)) begin
            errors++;
            $display("FAIL reset_mid_grant: got %b expected %b", obs, expv(4'b0000, 2'd0, 1'b0));
        end
        sync_reset = 1'b0;
        step();
        // Pointer restarts at N_REQ-1, so the lowest index (2) wins, not 3.
        checks++;
        if (obs !== expv(4'b0100, 2'd2, 1'b0)) begin
            errors++;
            $display("FAIL post_reset_lowest: got %b expected %b", obs, expv(4'b0100, 2'd2, 1'b0));
        end
    endtask

    initial begin
        sync_reset = 1'b1;
        req        = 4'b0000;
        test_reset();
        test_expiry();
        test_renewal();
        test_early_release();
        test_release_expiry_wrap();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
